// File: rtl/tpu_sequencer.sv
// Job sequencer for the systolic TPU: weight reload, activation streaming from the
// Unified Buffer, and result SRAM write-back after a fixed pipeline latency.
module tpu_sequencer #(
   parameter int ADDRESSSIZE      = 10,
   parameter int ADDRESSSIZE_fifo = 2,
   parameter int RESULT_LATENCY   = 24
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        start,
   input  logic [ADDRESSSIZE-1:0]      num_vectors,
   input  logic [ADDRESSSIZE-1:0]      ub_base,
   input  logic [ADDRESSSIZE_fifo-1:0] weight_sel,
   output logic                        busy,
   output logic [ADDRESSSIZE-1:0]      ub_address,
   output logic                        ub_read_valid,
   output logic [ADDRESSSIZE_fifo-1:0] fifo_address,
   output logic                        we_rl,
   output logic                        res_write_enable,
   output logic [ADDRESSSIZE-1:0]      res_address,
   output logic                        end_
);

   // state    | meaning
   // ---------+------------------------------------------------------------
   // S_IDLE   | waiting for start; inputs latched when start is accepted
   // S_W_ADDR | weight-store address presented
   // S_W_LOAD | weight-store address held, we_rl strobe to the array
   // S_STREAM | one UB activation read per cycle, num_vectors cycles
   // S_DRAIN  | reads done, waiting for the last result write
   // S_DONE   | end_ pulse, back to idle next cycle
   typedef enum logic [2:0] {
      S_IDLE,
      S_W_ADDR,
      S_W_LOAD,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                      state, state_nxt;
   logic [ADDRESSSIZE-1:0]      nv_q;
   logic [ADDRESSSIZE-1:0]      base_q;
   logic [ADDRESSSIZE_fifo-1:0] wsel_q;
   logic [ADDRESSSIZE-1:0]      issue_cnt;
   logic [ADDRESSSIZE-1:0]      write_cnt;
   logic [ADDRESSSIZE-1:0]      write_cnt_nxt;
   logic [RESULT_LATENCY-1:0]   vld_pipe;

   assign res_write_enable = vld_pipe[RESULT_LATENCY-1];
   assign write_cnt_nxt    = write_cnt + ADDRESSSIZE'(res_write_enable);
   assign res_address      = res_write_enable ? (base_q + write_cnt) : '0;

   always_comb begin
      state_nxt     = state;
      busy          = (state != S_IDLE);
      ub_address    = '0;
      ub_read_valid = 1'b0;
      fifo_address  = '0;
      we_rl         = 1'b0;
      end_          = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (num_vectors == '0) ? S_DONE : S_W_ADDR;
            end
         end
         S_W_ADDR: begin
            fifo_address = wsel_q;
            state_nxt    = S_W_LOAD;
         end
         S_W_LOAD: begin
            fifo_address = wsel_q;
            we_rl        = 1'b1;
            state_nxt    = S_STREAM;
         end
         S_STREAM: begin
            ub_read_valid = 1'b1;
            ub_address    = base_q + issue_cnt;
            if (issue_cnt == nv_q - ADDRESSSIZE'(1)) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Look at the post-increment count so end_ lands right after the last write.
            if (write_cnt_nxt == nv_q) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            end_      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         nv_q      <= '0;
         base_q    <= '0;
         wsel_q    <= '0;
         issue_cnt <= '0;
         write_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && start) begin
            nv_q      <= num_vectors;
            base_q    <= ub_base;
            wsel_q    <= weight_sel;
            issue_cnt <= '0;
            write_cnt <= '0;
         end else begin
            if (state == S_STREAM) begin
               issue_cnt <= issue_cnt + ADDRESSSIZE'(1);
            end
            write_cnt <= write_cnt_nxt;
         end
      end
   end

   // Read-valid delay line matching the array + result path latency.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= ub_read_valid;
         for (int i = 1; i < RESULT_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Randomized scoreboard bench for tpu_sequencer: a cycle-arithmetic job model
// predicts every strobe; a negedge monitor pops and compares.
module tb_tpu_sequencer;
   localparam int AW  = 10;
   localparam int FW  = 2;
   localparam int LAT = 24;
   localparam int AMOD = 1 << AW;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic [AW-1:0] num_vectors;
   logic [AW-1:0] ub_base;
   logic [FW-1:0] weight_sel;
   logic          busy;
   logic [AW-1:0] ub_address;
   logic          ub_read_valid;
   logic [FW-1:0] fifo_address;
   logic          we_rl;
   logic          res_write_enable;
   logic [AW-1:0] res_address;
   logic          end_;

   tpu_sequencer #(
      .ADDRESSSIZE(AW), .ADDRESSSIZE_fifo(FW), .RESULT_LATENCY(LAT)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .num_vectors(num_vectors),
      .ub_base(ub_base), .weight_sel(weight_sel), .busy(busy),
      .ub_address(ub_address), .ub_read_valid(ub_read_valid),
      .fifo_address(fifo_address), .we_rl(we_rl),
      .res_write_enable(res_write_enable), .res_address(res_address), .end_(end_)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   // 0: we_rl/fifo_address, 1: UB reads, 2: result writes, 3: end_
   ev_t q[4][$];
   int  job_end     = -1;
   int  last_accept = -1;
   int  n_checks    = 0;
   int  n_pass      = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic sb(input int k, input string nm, input bit strobe, input int val);
      ev_t e;
      while (q[k].size() > 0 && q[k][0].cyc < cyc) begin
         chk({nm, "_missing_at"}, cyc, q[k][0].cyc);
         void'(q[k].pop_front());
      end
      if (strobe) begin
         if (q[k].size() == 0) chk({nm, "_unexpected_queue_size"}, q[k].size(), 1);
         else begin
            e = q[k].pop_front();
            chk({nm, "_cycle"}, cyc, e.cyc);
            chk({nm, "_value"}, val, e.val);
         end
      end
   endtask

   // Job model: everything follows from the accept cycle by plain arithmetic.
   task automatic model_accept(input int a, input int n, input int b, input int w);
      last_accept = a;
      if (n == 0) begin
         q[3].push_back('{a + 1, 1});
         job_end = a + 1;
      end else begin
         q[0].push_back('{a + 2, w});
         for (int i = 0; i < n; i++) begin
            q[1].push_back('{a + 3 + i, (b + i) % AMOD});
            q[2].push_back('{a + 3 + i + LAT, (b + i) % AMOD});
         end
         job_end = a + n + LAT + 3;
         q[3].push_back('{job_end, 1});
      end
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         chk("reset_outputs", int'({busy, we_rl, ub_read_valid, res_write_enable, end_})
             | int'(ub_address) | int'(fifo_address) | int'(res_address), 0);
      end else begin
         chk("busy", busy, (cyc > last_accept && cyc <= job_end) ? 1 : 0);
         sb(0, "we_rl", we_rl, fifo_address);
         sb(1, "ub_read", ub_read_valid, ub_address);
         sb(2, "res_write", res_write_enable, res_address);
         sb(3, "end", end_, busy);
         if (!ub_read_valid)    chk("ub_addr_idle", ub_address, 0);
         if (!res_write_enable) chk("res_addr_idle", res_address, 0);
         if (!busy)             chk("fifo_addr_idle", fifo_address, 0);
         if (start && cyc > job_end)
            model_accept(cyc, num_vectors, ub_base, weight_sel);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int n, input int b, input int w);
      num_vectors = AW'(n);
      ub_base     = AW'(b);
      weight_sel  = FW'(w);
      start       = 1'b1;
      tick();
      start       = 1'b0;
      num_vectors = AW'($urandom);
      ub_base     = AW'($urandom);
      weight_sel  = FW'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (cyc <= job_end && n < 3000) begin
         tick();
         n++;
      end
      chk("idle_timeout", (cyc <= job_end) ? 1 : 0, 0);
   endtask

   initial begin
      rstn = 1'b0;
      start = 1'b0;
      num_vectors = '0;
      ub_base = '0;
      weight_sel = '0;
      repeat (3) tick();
      rstn = 1'b1;
      tick();

      start_job(4, 16, 2);
      wait_idle();
      start_job(0, 55, 3);
      wait_idle();
      tick();
      start_job(3, 1022, 1);
      wait_idle();
      start_job(2, 1023, 0);
      wait_idle();

      // start re-pulsed mid-stream, then back-to-back start right after end_
      start_job(6, 100, 3);
      repeat (3) tick();
      start_job(9, 300, 1);
      begin
         int n = 0;
         while (cyc < job_end + 1 && n < 200) begin
            tick();
            n++;
         end
         chk("b2b_wait_timeout", (cyc == job_end + 1) ? 1 : 0, 1);
      end
      start_job(2, 500, 0);
      wait_idle();

      // reset in DRAIN with two writes still outstanding
      start_job(4, 16, 1);
      begin
         int a = last_accept;
         while (cyc < a + 29) tick();
      end
      rstn = 1'b0;
      #1;
      chk("async_reset_outputs", int'({busy, we_rl, ub_read_valid, res_write_enable, end_})
          | int'(ub_address) | int'(fifo_address) | int'(res_address), 0);
      for (int k = 0; k < 4; k++) q[k].delete();
      job_end = cyc - 1;
      last_accept = cyc - 1;
      repeat (3) tick();
      rstn = 1'b1;
      repeat (40) tick();
      start_job(1, 7, 3);
      wait_idle();

      // random traffic: the model decides which start pulses are accepted
      for (int c = 0; c < 1500; c++) begin
         start       = ($urandom_range(0, 9) == 0);
         num_vectors = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 1))
                                                   : AW'($urandom_range(0, 40));
         ub_base     = AW'($urandom);
         weight_sel  = FW'($urandom);
         tick();
      end
      start = 1'b0;
      wait_idle();

      start_job(1023, 900, 2);
      wait_idle();
      repeat (3) tick();

      for (int k = 0; k < 4; k++) chk("leftover_events", q[k].size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
